// File: rtl/divider_signed_seq_if.sv
// Handshake and data bundle for divider_signed_seq.
//   master : operand producer / result consumer (drives in_valid, a, b, sign, out_ready)
//   slave  : the divider (drives in_ready, out_valid, quotient, remainder, div_zero)
interface divider_signed_seq_if #(
  parameter int SIZE = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            sign;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] quotient;
  logic [SIZE-1:0] remainder;
  logic            div_zero;

  modport master (
    output in_valid, a, b, sign, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, a, b, sign, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/divider_signed_seq.sv
// Iterative radix-2 restoring divider with DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle; divide-by-zero and signed overflow finish early.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : divider_signed_seq_if.slave
//          in_valid/in_ready + a, b, sign   -> operand handshake
//          out_valid/out_ready + quotient, remainder, div_zero -> result handshake
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for operands, in_ready high
// PREP   | take magnitudes, record result signs, detect special cases
// DIV    | one restoring step per cycle, SIZE steps total
// FIX    | apply result signs, register quotient/remainder
// DONE   | result held until out_ready
module divider_signed_seq #(
  parameter int SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  divider_signed_seq_if.slave   bus
);

  localparam int CW = $clog2(SIZE);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [SIZE-1:0] MSB_ONLY = {1'b1, {(SIZE-1){1'b0}}};
  localparam logic [SIZE-1:0] ALL_ONES = {SIZE{1'b1}};

  logic [2:0]      state;
  logic [SIZE-1:0] a_r;
  logic [SIZE-1:0] b_r;
  logic            sign_r;
  logic [SIZE-1:0] dvd;      // dividend bits still to be brought down
  logic [SIZE-1:0] dvs;      // divisor magnitude
  logic [SIZE-1:0] pr;       // partial remainder (always < dvs, so SIZE bits suffice)
  logic [SIZE-1:0] qr;       // quotient magnitude being built
  logic [CW-1:0]   cnt;
  logic            neg_q;
  logic            neg_r;
  logic [SIZE-1:0] q_out;
  logic [SIZE-1:0] r_out;
  logic            dz_out;

  logic [SIZE-1:0] mag_a;
  logic [SIZE-1:0] mag_b;
  logic [SIZE:0]   shifted;
  logic [SIZE:0]   diff;
  logic            accept;
  logic            release_res;

  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude.
  assign mag_a = (sign_r & a_r[SIZE-1]) ? (~a_r + 1'b1) : a_r;
  assign mag_b = (sign_r & b_r[SIZE-1]) ? (~b_r + 1'b1) : b_r;

  // Trial subtraction on the SIZE+1 bit shifted remainder; a set MSB means
  // the divisor did not fit.
  assign shifted = {pr, dvd[SIZE-1]};
  assign diff    = shifted - {1'b0, dvs};

  assign accept      = bus.in_valid & bus.in_ready;
  assign release_res = bus.out_valid & bus.out_ready;

  assign bus.in_ready  = (state == S_IDLE) & ~rst;
  assign bus.out_valid = (state == S_DONE);
  assign bus.quotient  = q_out;
  assign bus.remainder = r_out;
  assign bus.div_zero  = dz_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      sign_r <= 1'b0;
      dvd    <= '0;
      dvs    <= '0;
      pr     <= '0;
      qr     <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      q_out  <= '0;
      r_out  <= '0;
      dz_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            sign_r <= bus.sign;
            state  <= S_PREP;
          end
        end

        S_PREP: begin
          dvd   <= mag_a;
          dvs   <= mag_b;
          pr    <= '0;
          qr    <= '0;
          cnt   <= CW'(SIZE - 1);
          neg_q <= sign_r & (a_r[SIZE-1] ^ b_r[SIZE-1]);
          neg_r <= sign_r & a_r[SIZE-1];
          if (b_r == '0) begin
            q_out  <= ALL_ONES;
            r_out  <= a_r;
            dz_out <= 1'b1;
            state  <= S_DONE;
          end else if (sign_r && (a_r == MSB_ONLY) && (b_r == ALL_ONES)) begin
            q_out  <= a_r;
            r_out  <= '0;
            dz_out <= 1'b0;
            state  <= S_DONE;
          end else begin
            state <= S_DIV;
          end
        end

        S_DIV: begin
          dvd <= {dvd[SIZE-2:0], 1'b0};
          qr  <= {qr[SIZE-2:0], ~diff[SIZE]};
          if (!diff[SIZE]) begin
            pr <= diff[SIZE-1:0];
          end else begin
            pr <= shifted[SIZE-1:0];
          end
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        S_FIX: begin
          q_out  <= neg_q ? (~qr + 1'b1) : qr;
          r_out  <= neg_r ? (~pr + 1'b1) : pr;
          dz_out <= 1'b0;
          state  <= S_DONE;
        end

        S_DONE: begin
          if (release_res) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_signed_seq.sv
module tb_divider_signed_seq;

  localparam int SIZE = 32;
  localparam logic [31:0] MSB_ONLY = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  logic clk;
  logic rst;

  int checks;
  int errors;

  logic [31:0] last_q;
  logic [31:0] last_r;
  logic        last_dz;

  divider_signed_seq_if #(.SIZE(SIZE)) bus ();

  divider_signed_seq #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output int lat);
    longint sa;
    longint sb;
    dz  = 1'b0;
    lat = SIZE + 2;
    if (b == 32'd0) begin
      q   = ALL_ONES;
      r   = a;
      dz  = 1'b1;
      lat = 1;
    end else if (s && a == MSB_ONLY && b == ALL_ONES) begin
      q   = a;
      r   = 32'd0;
      lat = 1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at a negedge with the divider idle. Leaves the result pending in DONE.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
    int n;
    int exp_lat;
    logic busy_ready;
    ref_div(ta, tb_v, ts, last_q, last_r, last_dz, exp_lat);
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tb_v;
    bus.sign     = ts;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    busy_ready = 1'b0;
    // Keep in_valid high with scrambled operands: must be ignored while busy.
    bus.a    = $urandom;
    bus.b    = $urandom;
    bus.sign = 1'($urandom_range(0, 1));
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) busy_ready = 1'b1;
      @(posedge clk);
      n++;
      @(negedge clk);
      bus.a    = $urandom;
      bus.b    = $urandom;
      bus.sign = 1'($urandom_range(0, 1));
    end
    bus.in_valid = 1'b0;
    check("busy_in_ready", 64'(busy_ready), 64'd0);
    check("latency", 64'(n), 64'(exp_lat));
    check("quotient", 64'(bus.quotient), 64'(last_q));
    check("remainder", 64'(bus.remainder), 64'(last_r));
    check("div_zero", 64'(bus.div_zero), 64'(last_dz));
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_cleared", 64'(bus.out_valid), 64'd0);
    check("in_ready_after", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
    start_op(ta, tb_v, ts);
    finish_op();
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          mode;
    checks = 0;
    errors = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sign      = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_quotient", 64'(bus.quotient), 64'd0);
    check("rst_remainder", 64'(bus.remainder), 64'd0);
    check("rst_div_zero", 64'(bus.div_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(32'd5, 32'd0, 1'b0);
    run_op(32'd5, 32'd0, 1'b1);
    run_op(MSB_ONLY, ALL_ONES, 1'b1);
    run_op(MSB_ONLY, ALL_ONES, 1'b0);

    // Result held under back-pressure while new operands are offered
    start_op(32'd1000, 32'd33, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.sign     = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_quotient", 64'(bus.quotient), 64'(last_q));
      check("hold_remainder", 64'(bus.remainder), 64'(last_r));
    end
    bus.in_valid = 1'b0;
    finish_op();
    run_op(32'd12345, 32'd100, 1'b0);

    // Reset in the middle of an iteration
    bus.in_valid = 1'b1;
    bus.a        = 32'd77777;
    bus.b        = 32'd13;
    bus.sign     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_quotient", 64'(bus.quotient), 64'd0);
    check("midrst_remainder", 64'(bus.remainder), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);

    // Randomized operands, biased toward the interesting corners
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 7);
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case (mode)
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = MSB_ONLY; rb = ALL_ONES; end
        3: rb = 32'd0 - 32'($urandom_range(1, 15));
        4: ra = MSB_ONLY;
        default: ;
      endcase
      run_op(ra, rb, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
